// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring division.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete with err=1.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            err
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              err_q, err_d;

  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod, prod_s;

`ifdef MULDIV_DIV_EN
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   q_s, r_s;
`endif

  // Operand signedness: divides are signed when op[0]=0; MULHSU treats only rs1 as signed.
  always_comb begin
    a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn = op[2] ? ~op[0] : ~op[1];
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    sum      = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    prod     = {hi_q, lo_q};
    prod_s   = neg_q ? -prod : prod;
`ifdef MULDIV_DIV_EN
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    a_d       = a_q;
    trial     = {hi_q, lo_q[XLEN-1]};
    diff      = trial[XLEN-1:0] - opnd_q;
    q_s       = neg_q ? -lo_q : lo_q;
    r_s       = neg_rem_q ? -hi_q : hi_q;
    if (dz_q) begin
      q_s = '1;
      r_s = a_q;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          neg_d   = sa ^ sb;
          busy_d  = 1'b1;
          if (op[2]) begin
            lo_d   = mag_a;
            opnd_d = mag_b;
          end else begin
            lo_d   = mag_b;
            opnd_d = mag_a;
          end
`ifdef MULDIV_DIV_EN
          neg_rem_d = sa;
          dz_d      = (b == '0);
          a_d       = a;
`endif
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) state_d = StFin;
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
          if (trial >= {1'b0, opnd_q}) begin
            hi_d = diff;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
`else
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
`endif
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b0;
        if (op_q[2]) begin
`ifdef MULDIV_DIV_EN
          result_d = op_q[1] ? r_s : q_s;
`else
          result_d = '0;
          err_d    = 1'b1;
`endif
        end else if (op_q[1:0] == 2'b00) begin
          result_d = prod_s[XLEN-1:0];
        end else begin
          result_d = prod_s[2*XLEN-1:XLEN];
        end
      end
      default: state_d = StIdle;
    endcase

    // A flush wins over everything, including a completing op and a same-cycle start.
    if (kill) begin
      state_d  = StIdle;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      err_q     <= err_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      a_q       <= a_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model checked every cycle, plus directed literals.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, err;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  // Reference arithmetic from RV32M definitions; returns {err, result}.
  function automatic logic [32:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    logic        e;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    e  = 1'b0;
    r  = 32'd0;
    p  = 64'd0;
    case (mop)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, mb}); r = p[63:32]; end
      3'd3: begin p = {32'd0, ma} * {32'd0, mb}; r = p[63:32]; end
      3'd4: begin
        if (mb == 32'd0) r = 32'hFFFF_FFFF;
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = ma;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (mb == 32'd0) ? 32'hFFFF_FFFF : ma / mb;
      3'd6: begin
        if (mb == 32'd0) r = ma;
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (mb == 32'd0) ? ma : ma % mb;
    endcase
`ifndef MULDIV_DIV_EN
    if (mop[2]) begin
      r = 32'd0;
      e = 1'b1;
    end
`endif
    return {e, r};
  endfunction

  // Transaction-level timing model: done arrives XLEN+1 edges after acceptance.
  int          m_left;
  logic        m_busy, m_done, m_err;
  logic [31:0] m_res;
  logic [32:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_res  <= 32'd0;
      m_pend <= 33'd0;
    end else begin
      m_done <= 1'b0;
      if (kill) begin
        m_left <= 0;
        m_busy <= 1'b0;
      end else if (m_left == 0) begin
        if (start) begin
          m_pend <= model(op, a, b);
          m_left <= XLEN + 1;
          m_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_res  <= m_pend[31:0];
          m_err  <= m_pend[32];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_vs_model", 32'(busy), 32'(m_busy));
      check("done_vs_model", 32'(done), 32'(m_done));
      check("result_vs_model", result, m_res);
      check("err_vs_model", 32'(err), 32'(m_err));
    end
  end

  // Waits up to 40 edges for done; n = edges waited (0 if never seen).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // Called at posedge+1; lit is the full-RV32M answer.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] lit);
    logic [31:0] ex_r;
    logic        ex_e;
    int          n;
    ex_r = lit;
    ex_e = 1'b0;
`ifndef MULDIV_DIV_EN
    if (o[2]) begin
      ex_r = 32'd0;
      ex_e = 1'b1;
    end
`endif
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    if (n == 0) $display("FAIL %s timeout: no done within 40 cycles", name);
    check({name, "_latency"}, 32'(n), 32'(XLEN + 1));
    check({name, "_result"}, result, ex_r);
    check({name, "_err"}, 32'(err), 32'(ex_e));
    last_res = ex_r;
  endtask

  initial begin
    int n;
    int dcnt;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul_7_m3", OpMul, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min", OpMulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_m1", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mul_min_m1", OpMul, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("mulh_min_m1", OpMulh, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    do_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    do_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    do_op("divu_m7_2", OpDivu, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
    do_op("remu_m7_2", OpRemu, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);
    do_op("div_by0", OpDiv, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    do_op("rem_by0", OpRem, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    do_op("divu_by0", OpDivu, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    do_op("remu_by0", OpRemu, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);
    do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    do_op("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2);
    do_op("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1);
    do_op("mul_3_4", OpMul, 32'd3, 32'd4, 32'd12);

    // Second start at E5 must be ignored.
    start = 1'b1; op = OpMul; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = OpMulhu; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    if (n == 0) $display("FAIL busy_start timeout: no done within 40 cycles");
    check("busy_start_latency", 32'(n + 5), 32'(XLEN + 1));
    check("busy_start_result", result, 32'd42);
    last_res = 32'd42;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("busy_start_single_done", 32'(dcnt), 32'd0);

    // Kill at E10 of a divide.
    start = 1'b1; op = OpDiv; a = 32'd100; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("kill_no_done", 32'(dcnt), 32'd0);
    check("kill_result_kept", result, last_res);

    // Kill and start together in idle: kill wins.
    start = 1'b1; kill = 1'b1; op = OpMul; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    check("kill_start_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back after a completed op, then async reset mid-op at E7.
    do_op("mul_b2b_a", OpMul, 32'd5, 32'd9, 32'd45);
    do_op("mulhu_b2b_b", OpMulhu, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002);
    start = 1'b1; op = OpMul; a = 32'd11; b = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("mul_after_rst", OpMul, 32'd11, 32'd13, 32'd143);
    do_op("divu_after_rst", OpDivu, 32'd100, 32'd7, 32'd14);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
